// File: rtl/pkt_tx_ctrl_pkg.sv
// Shared router definitions for the output-port packet reader.
// Holds the default byte/length widths, the header length-field position
// and the reader FSM state encoding.
package pkt_tx_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int LEN_WIDTH_DEF  = 6;

  // Payload length lives in the low bits of the header byte.
  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_LEN_MSB = HDR_LEN_LSB + LEN_WIDTH_DEF - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } tx_state_e;

endpackage

// File: rtl/pkt_tx_ctrl_if.sv
// FIFO read side plus output channel of one router port.
//   fifo_data/fifo_empty/fifo_pop : first-word fall-through FIFO head
//   tx_data/tx_valid/tx_ready     : output valid/ready channel
//   tx_sop/tx_eop                 : header / CRC beat markers
// master: the packet reader; slave: the FIFO + sink side.
interface pkt_tx_ctrl_if
  import pkt_tx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  tx_sop;
  logic                  tx_eop;

  modport master (
    input  fifo_data, fifo_empty, tx_ready,
    output fifo_pop, tx_data, tx_valid, tx_sop, tx_eop
  );

  modport slave (
    output fifo_data, fifo_empty, tx_ready,
    input  fifo_pop, tx_data, tx_valid, tx_sop, tx_eop
  );

endinterface

// File: rtl/pkt_tx_ctrl.sv
// Output-port packet reader. Pops whole packets (header, L payload bytes,
// CRC) from the port FIFO and streams them through a one-beat output
// register with valid/ready, marking sop/eop, inserting IFG_CYCLES idle
// cycles after each packet and counting transmitted packets.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   bus         : FIFO head + output channel (master modport)
//   pkt_done    : one-cycle pulse after the eop beat is accepted
//   pkt_cnt     : packets fully transmitted, wraps
module pkt_tx_ctrl
  import pkt_tx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int IFG_CYCLES = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pkt_tx_ctrl_if.master        bus,
  output logic                 pkt_done,
  output logic [CNT_WIDTH-1:0] pkt_cnt
);

  // rem carries one extra bit so L = 2^LEN_WIDTH-1 plus the CRC fits.
  localparam int RW      = LEN_WIDTH + 1;
  localparam int GW      = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int LEN_MSB = HDR_LEN_LSB + LEN_WIDTH - 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  tx_state_e             state, state_nxt;
  logic [RW-1:0]         rem;
  logic [GW-1:0]         gap_cnt;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic                  tx_valid_q, tx_sop_q, tx_eop_q;
  logic                  permit, load, accept, last_beat, drain_done;

  assign permit     = (state == ST_IDLE) || (state == ST_SEND);
  assign accept     = tx_valid_q && bus.tx_ready;
  assign load       = permit && !bus.fifo_empty && (!tx_valid_q || bus.tx_ready);
  assign last_beat  = (state == ST_SEND) && (rem == RW'(1));
  assign drain_done = (state == ST_DRAIN) && accept;

  // A held reset must never advance the FIFO even though IDLE would load.
  assign bus.fifo_pop = load && rst_n;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_sop   = tx_sop_q;
  assign bus.tx_eop   = tx_eop_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (load) state_nxt = ST_SEND;
      ST_SEND:  if (load && last_beat) state_nxt = ST_DRAIN;
      ST_DRAIN: if (accept) state_nxt = (IFG_CYCLES > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_sop_q   <= 1'b0;
      tx_eop_q   <= 1'b0;
      rem        <= '0;
      gap_cnt    <= '0;
      pkt_done   <= 1'b0;
      pkt_cnt    <= '0;
    end else begin
      if (load) begin
        tx_data_q  <= bus.fifo_data;
        tx_valid_q <= 1'b1;
        if (state == ST_IDLE) begin
          tx_sop_q <= 1'b1;
          tx_eop_q <= 1'b0;
          rem      <= RW'(bus.fifo_data[LEN_MSB:HDR_LEN_LSB]) + RW'(1);
        end else begin
          tx_sop_q <= 1'b0;
          tx_eop_q <= last_beat;
          rem      <= rem - RW'(1);
        end
      end else if (accept) begin
        tx_valid_q <= 1'b0;
      end

      pkt_done <= drain_done;
      if (drain_done) pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);

      // Counter is cleared while draining so every gap starts from zero.
      if (state == ST_DRAIN)    gap_cnt <= '0;
      else if (state == ST_GAP) gap_cnt <= gap_cnt + GW'(1);
    end
  end

endmodule

// File: tb/tb_pkt_tx_ctrl.sv
// Self-checking bench for pkt_tx_ctrl: a queue-based FIFO and a packet-level
// expected beat stream built from header length fields, compared against
// the beats the sink actually accepts.
module tb_pkt_tx_ctrl;

  localparam int DW  = 8;
  localparam int LW  = 6;
  localparam int IFG = 2;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pkt_done;
  logic [CW-1:0] pkt_cnt;

  pkt_tx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  pkt_tx_ctrl #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW), .IFG_CYCLES(IFG), .CNT_WIDTH(CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .pkt_done (pkt_done),
    .pkt_cnt  (pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] data; logic sop; logic eop; } beat_t;
  typedef struct packed { logic vld; logic sop; logic eop; } trc_t;

  logic [7:0] fifo_q[$];
  beat_t      exp_q[$];
  beat_t      obs_q[$];
  trc_t       trc_q[$];
  bit         hold_empty;
  int         pops, stall_err, done_cyc, exp_cnt;
  int         n_chk, n_fail;

  task automatic drive_fifo();
    bus.fifo_empty = hold_empty || (fifo_q.size() == 0);
    bus.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  // Packet model: header, hdr[LW-1:0] payload bytes, CRC.
  task automatic push_pkt(input logic [7:0] hdr, input logic [7:0] crc,
                          input logic [7:0] base, input bit rnd);
    int len;
    logic [7:0] b;
    len = int'(hdr[LW-1:0]);
    fifo_q.push_back(hdr);
    exp_q.push_back({hdr, 1'b1, 1'b0});
    for (int i = 0; i < len; i++) begin
      b = rnd ? 8'($urandom) : 8'(int'(base) * (i + 1));
      fifo_q.push_back(b);
      exp_q.push_back({b, 1'b0, 1'b0});
    end
    fifo_q.push_back(crc);
    exp_q.push_back({crc, 1'b0, 1'b1});
    drive_fifo();
  endtask

  task automatic push_rnd(input int lmin, input int lmax);
    logic [7:0] h;
    h = 8'($urandom);
    h[LW-1:0] = LW'($urandom_range(lmin, lmax));
    push_pkt(h, 8'($urandom), 8'h00, 1'b1);
  endtask

  task automatic run_cycle(input bit rdy);
    bit acc, pop, stall;
    beat_t snap;
    bus.tx_ready = rdy;
    drive_fifo();
    #1;
    acc   = bus.tx_valid && bus.tx_ready;
    pop   = bus.fifo_pop;
    stall = bus.tx_valid && !bus.tx_ready;
    snap  = {bus.tx_data, bus.tx_sop, bus.tx_eop};
    trc_q.push_back({bus.tx_valid, bus.tx_sop, bus.tx_eop});
    if (acc) obs_q.push_back(snap);
    @(posedge clk);
    #1;
    if (pop) begin
      pops++;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    if (stall && (!bus.tx_valid || snap !== {bus.tx_data, bus.tx_sop, bus.tx_eop}))
      stall_err++;
    if (pkt_done) done_cyc++;
    drive_fifo();
  endtask

  // mode 0: ready high, 1: ready 1,0,0 repeating, 2: random ready
  task automatic run_until(input int n, input int mode, input int budget);
    int k;
    bit rdy;
    k = 0;
    while (obs_q.size() < n && k < budget) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (k % 3) == 0;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      run_cycle(rdy);
      k++;
    end
    n_chk++;
    if (obs_q.size() < n) begin
      n_fail++;
      $display("FAIL beat_timeout: got %0d beats, required %0d within %0d cycles",
               obs_q.size(), n, budget);
    end
    repeat (5) run_cycle(1'b1);
  endtask

  function automatic int stream_errs();
    int e;
    e = 0;
    if (obs_q.size() != exp_q.size()) e++;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) e++;
    return e;
  endfunction

  task automatic clr();
    obs_q.delete(); exp_q.delete(); trc_q.delete();
    pops = 0; stall_err = 0; done_cyc = 0;
  endtask

  task automatic test_reset();
    clr();
    rst_n = 1'b0;
    push_pkt(8'h83, 8'h5A, 8'h11, 1'b0);
    repeat (3) run_cycle(1'b1);
    n_chk++;
    if (bus.fifo_pop !== 1'b0 || pops != 0) begin
      n_fail++;
      $display("FAIL reset_pop: fifo_pop=%b pops=%0d, required 0", bus.fifo_pop, pops);
    end
    n_chk++;
    if ({bus.tx_data, bus.tx_valid, bus.tx_sop, bus.tx_eop, pkt_done, pkt_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: data=%h v=%b sop=%b eop=%b done=%b cnt=%0d, required all 0",
               bus.tx_data, bus.tx_valid, bus.tx_sop, bus.tx_eop, pkt_done, pkt_cnt);
    end
    rst_n = 1'b1;
    run_cycle(1'b1);
    n_chk++;
    if (bus.tx_valid !== 1'b1 || bus.tx_sop !== 1'b1 || bus.tx_eop !== 1'b0 ||
        bus.tx_data !== 8'h83 || pops != 1) begin
      n_fail++;
      $display("FAIL reset_first_load: v=%b sop=%b eop=%b data=%h pops=%0d, required 1 1 0 83 1",
               bus.tx_valid, bus.tx_sop, bus.tx_eop, bus.tx_data, pops);
    end
    run_until(5, 0, 40);
    exp_cnt = 1;
    n_chk++;
    if (stream_errs() != 0 || pkt_cnt !== CW'(exp_cnt)) begin
      n_fail++;
      $display("FAIL reset_packet: errs=%0d cnt=%0d, required 0 and %0d",
               stream_errs(), pkt_cnt, exp_cnt);
    end
  endtask

  task automatic test_single();
    int first, run, total;
    clr();
    push_pkt(8'h83, 8'h5A, 8'h11, 1'b0);
    run_until(5, 0, 40);
    exp_cnt++;
    first = -1; run = 0; total = 0;
    foreach (trc_q[i]) begin
      if (trc_q[i].vld) begin
        total++;
        if (first < 0) first = i;
        if (i == first + run) run++;
      end
    end
    n_chk++;
    if (stream_errs() != 0) begin
      n_fail++;
      $display("FAIL single_stream: errs=%0d, required 0", stream_errs());
    end
    n_chk++;
    if (run != 5 || total != 5) begin
      n_fail++;
      $display("FAIL single_contig: run=%0d total=%0d, required 5 5", run, total);
    end
    n_chk++;
    if (pops != 5 || done_cyc != 1 || pkt_cnt !== CW'(exp_cnt)) begin
      n_fail++;
      $display("FAIL single_counts: pops=%0d done=%0d cnt=%0d, required 5 1 %0d",
               pops, done_cyc, pkt_cnt, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    clr();
    push_pkt(8'h83, 8'h5A, 8'h11, 1'b0);
    run_until(5, 1, 60);
    exp_cnt++;
    n_chk++;
    if (stream_errs() != 0 || stall_err != 0) begin
      n_fail++;
      $display("FAIL bp_stream: errs=%0d stall_err=%0d, required 0 0", stream_errs(), stall_err);
    end
    n_chk++;
    if (pops != 5 || done_cyc != 1 || pkt_cnt !== CW'(exp_cnt)) begin
      n_fail++;
      $display("FAIL bp_counts: pops=%0d done=%0d cnt=%0d, required 5 1 %0d",
               pops, done_cyc, pkt_cnt, exp_cnt);
    end
  endtask

  task automatic test_zero_len();
    clr();
    push_pkt(8'h40, 8'hA7, 8'h00, 1'b0);
    run_until(2, 2, 40);
    exp_cnt++;
    n_chk++;
    if (stream_errs() != 0 || obs_q.size() != 2) begin
      n_fail++;
      $display("FAIL zero_stream: errs=%0d beats=%0d, required 0 2", stream_errs(), obs_q.size());
    end
    n_chk++;
    if (pops != 2 || done_cyc != 1 || pkt_cnt !== CW'(exp_cnt)) begin
      n_fail++;
      $display("FAIL zero_counts: pops=%0d done=%0d cnt=%0d, required 2 1 %0d",
               pops, done_cyc, pkt_cnt, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int e, s;
    clr();
    push_rnd(1, 12);
    push_rnd(1, 12);
    run_until(exp_q.size(), 0, 200);
    exp_cnt += 2;
    e = -1; s = -1;
    foreach (trc_q[i]) begin
      if (e < 0 && trc_q[i].vld && trc_q[i].eop) e = i;
      else if (e >= 0 && s < 0 && trc_q[i].vld && trc_q[i].sop) s = i;
    end
    n_chk++;
    if (stream_errs() != 0) begin
      n_fail++;
      $display("FAIL b2b_stream: errs=%0d, required 0", stream_errs());
    end
    n_chk++;
    if (e < 0 || s < 0 || (s - e - 1) != IFG + 1) begin
      n_fail++;
      $display("FAIL b2b_gap: idle=%0d (eop@%0d sop@%0d), required %0d", s - e - 1, e, s, IFG + 1);
    end
    n_chk++;
    if (done_cyc != 2 || pkt_cnt !== CW'(exp_cnt)) begin
      n_fail++;
      $display("FAIL b2b_counts: done=%0d cnt=%0d, required 2 %0d", done_cyc, pkt_cnt, exp_cnt);
    end
  endtask

  task automatic test_underrun();
    clr();
    hold_empty = 1'b0;
    push_pkt(8'hC4, 8'h3C, 8'h00, 1'b1);
    run_cycle(1'b1);
    hold_empty = 1'b1;
    repeat (4) run_cycle(1'b1);
    n_chk++;
    if (pops != 1 || bus.tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL underrun_hold: pops=%0d v=%b, required 1 0", pops, bus.tx_valid);
    end
    hold_empty = 1'b0;
    run_until(6, 0, 40);
    exp_cnt++;
    n_chk++;
    if (stream_errs() != 0 || pops != 6 || done_cyc != 1) begin
      n_fail++;
      $display("FAIL underrun_resume: errs=%0d pops=%0d done=%0d, required 0 6 1",
               stream_errs(), pops, done_cyc);
    end
  endtask

  task automatic test_random();
    clr();
    repeat (6) push_rnd(0, 20);
    run_until(exp_q.size(), 2, 2000);
    exp_cnt += 6;
    n_chk++;
    if (stream_errs() != 0 || stall_err != 0 || pops != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_stream: errs=%0d stall_err=%0d pops=%0d, required 0 0 %0d",
               stream_errs(), stall_err, pops, exp_q.size());
    end
    n_chk++;
    if (done_cyc != 6 || pkt_cnt !== CW'(exp_cnt)) begin
      n_fail++;
      $display("FAIL random_counts: done=%0d cnt=%0d, required 6 %0d", done_cyc, pkt_cnt, exp_cnt);
    end
  endtask

  task automatic test_wrap();
    clr();
    repeat (18) push_rnd(0, 2);
    run_until(exp_q.size(), 0, 600);
    exp_cnt += 18;
    n_chk++;
    if (stream_errs() != 0 || done_cyc != 18 || pkt_cnt !== CW'(exp_cnt)) begin
      n_fail++;
      $display("FAIL wrap: errs=%0d done=%0d cnt=%0d, required 0 18 %0d",
               stream_errs(), done_cyc, pkt_cnt, exp_cnt % (1 << CW));
    end
  endtask

  task automatic test_reset_mid();
    clr();
    push_pkt(8'h0A, 8'hE1, 8'h00, 1'b1);
    repeat (4) run_cycle(1'b1);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.tx_valid !== 1'b0 || bus.tx_sop !== 1'b0 || bus.tx_eop !== 1'b0 ||
        pkt_cnt !== '0 || pkt_done !== 1'b0 || bus.fifo_pop !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: v=%b sop=%b eop=%b cnt=%0d done=%b pop=%b, required all 0",
               bus.tx_valid, bus.tx_sop, bus.tx_eop, pkt_cnt, pkt_done, bus.fifo_pop);
    end
    exp_cnt = 0;
    fifo_q.delete();
    clr();
    push_pkt(8'h85, 8'h77, 8'h00, 1'b1);
    repeat (2) run_cycle(1'b1);
    rst_n = 1'b1;
    run_until(7, 0, 40);
    exp_cnt++;
    n_chk++;
    if (stream_errs() != 0 || pops != 7 || pkt_cnt !== CW'(exp_cnt)) begin
      n_fail++;
      $display("FAIL midreset_restart: errs=%0d pops=%0d cnt=%0d, required 0 7 %0d",
               stream_errs(), pops, pkt_cnt, exp_cnt);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; exp_cnt = 0;
    hold_empty = 1'b0;
    bus.tx_ready = 1'b0;
    drive_fifo();
    test_reset();
    test_single();
    test_backpressure();
    test_zero_len();
    test_back_to_back();
    test_underrun();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
